// File: rtl/spsram_arbiter_if.sv
// rtl/spsram_arbiter_if.sv - requester and SRAM port bundle for spsram_arbiter
interface spsram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req0_rvalid;
    logic [DATA_WIDTH-1:0] req0_rdata;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  req1_rvalid;
    logic [DATA_WIDTH-1:0] req1_rdata;

    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_we;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_q;

    // Requesters and the SRAM sit on the master side.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  sram_addr, sram_we, sram_wdata,
        output sram_q
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output sram_addr, sram_we, sram_wdata,
        input  sram_q
    );
endinterface

// File: rtl/spsram_arbiter.sv
// rtl/spsram_arbiter.sv - two-port arbiter onto a single-port SRAM; SPSRAM_ARBITER_ROUND_ROBIN_EN selects round-robin
module spsram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spsram_arbiter_if.slave      bus
);
    logic                  grant0;
    logic                  grant1;
    logic [1:0]            rd_pend;
    logic [DATA_WIDTH-1:0] hold0;
    logic [DATA_WIDTH-1:0] hold1;

`ifdef SPSRAM_ARBITER_ROUND_ROBIN_EN
    // 1 means port 1 was granted last, so port 0 wins the next contention.
    logic last_grant;
`endif

    // Reset gates the grant so ready and sram_we drop without waiting for a clock.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef SPSRAM_ARBITER_ROUND_ROBIN_EN
                grant0 = last_grant;
                grant1 = !last_grant;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign bus.sram_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign bus.sram_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
    assign bus.sram_we    = (grant0 && bus.req0_we) || (grant1 && bus.req1_we);

    assign bus.req0_rvalid = rd_pend[0];
    assign bus.req1_rvalid = rd_pend[1];
    assign bus.req0_rdata  = rd_pend[0] ? bus.sram_q : hold0;
    assign bus.req1_rdata  = rd_pend[1] ? bus.sram_q : hold1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 2'b00;
            hold0   <= '0;
            hold1   <= '0;
`ifdef SPSRAM_ARBITER_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            rd_pend[0] <= grant0 && !bus.req0_we;
            rd_pend[1] <= grant1 && !bus.req1_we;
            if (rd_pend[0]) begin
                hold0 <= bus.sram_q;
            end
            if (rd_pend[1]) begin
                hold1 <= bus.sram_q;
            end
`ifdef SPSRAM_ARBITER_ROUND_ROBIN_EN
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
`endif
        end
    end
endmodule
